// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer and the decoder that feeds it.
package muldiv_ctrl_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX
  } state_e;

  typedef enum logic [1:0] {
    OP_MULT,
    OP_MULTU,
    OP_DIV,
    OP_DIVU
  } op_kind_e;

  function automatic logic is_signed_op(input op_kind_e k);
    return (k == OP_MULT) || (k == OP_DIV);
  endfunction

  function automatic logic is_div_op(input op_kind_e k);
    return (k == OP_DIV) || (k == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Decoder-side bundle for the multiply/divide block: strobes, operands, HI/LO and status.
interface muldiv_ctrl_if #(
  parameter int WIDTH = muldiv_ctrl_pkg::WIDTH_DEF
);
  logic             op_mult;
  logic             op_multu;
  logic             op_div;
  logic             op_divu;
  logic             op_mthi;
  logic             op_mtlo;
  logic             op_mfhi;
  logic             op_mflo;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hilo_rdata;

  modport master (
    output op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo, op_mfhi, op_mflo,
    output alu_a, alu_b,
    input  busy, stall, done, div_zero, hi, lo, hilo_rdata
  );

  modport slave (
    input  op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo, op_mfhi, op_mflo,
    input  alu_a, alu_b,
    output busy, stall, done, div_zero, hi, lo, hilo_rdata
  );
endinterface

// File: rtl/muldiv_ctrl_core.sv
// Iterative datapath: WIDTH-step shift-add multiply or restoring divide on operand
// magnitudes, followed by one sign-fix cycle that presents the HI/LO results.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for start; operands and sign flags latched on start
// ST_RUN  | one iteration per clock, cnt = 0..WIDTH-1
// ST_FIX  | res_hi/res_lo carry the sign-corrected result for one edge
module muldiv_core
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  op_kind_e         kind,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             fin,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);
  localparam int CW = $clog2(WIDTH);

  state_e             state;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   a_raw;
  logic               is_div_q;
  logic               neg_res;
  logic               neg_rem;
  logic               dz;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     msum;
  logic [WIDTH:0]     dshift;
  logic [WIDTH:0]     ddiff;
  logic               dge;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;

  always_comb begin
    a_neg    = is_signed_op(kind) && a[WIDTH-1];
    b_neg    = is_signed_op(kind) && b[WIDTH-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    msum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    dshift   = {acc_hi, acc_lo[WIDTH-1]};
    ddiff    = dshift - {1'b0, opnd};
    dge      = ~ddiff[WIDTH];
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_res ? -prod : prod;
    // Divide-by-zero bypasses the iterated result: all-ones quotient, raw dividend as remainder.
    if (dz) begin
      res_hi = a_raw;
      res_lo = '1;
    end else if (is_div_q) begin
      res_hi = neg_rem ? -acc_hi : acc_hi;
      res_lo = neg_res ? -acc_lo : acc_lo;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  assign fin = (state == ST_FIX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      a_raw    <= '0;
      is_div_q <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      dz       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            is_div_q <= is_div_op(kind);
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= is_div_op(kind) && a_neg;
            dz       <= is_div_op(kind) && (b == '0);
            a_raw    <= a;
            acc_hi   <= '0;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= ST_RUN;
            if (is_div_op(kind)) begin
              acc_lo <= a_mag;
              opnd   <= b_mag;
            end else begin
              acc_lo <= b_mag;
              opnd   <= a_mag;
            end
          end
        end
        ST_RUN: begin
          if (is_div_q) begin
            acc_hi <= dge ? ddiff[WIDTH-1:0] : dshift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], dge};
          end else begin
            acc_hi <= msum[WIDTH:1];
            acc_lo <= {msum[0], acc_lo[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1)) state <= ST_FIX;
        end
        ST_FIX: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner for the core: decodes mult/div/mthi/mtlo strobes by priority,
// drives the iterative core, raises stall on conflicts and muxes mfhi/mflo reads.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic           clk,
  input logic           rst_n,
  muldiv_ctrl_if.slave  bus
);
  op_kind_e         kind;
  logic             any_md;
  logic             any_op;
  logic             start;
  logic             core_busy;
  logic             fin;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             dz_q;

  always_comb begin
    kind = OP_MULTU;
    if (bus.op_div)       kind = OP_DIV;
    else if (bus.op_divu) kind = OP_DIVU;
    else if (bus.op_mult) kind = OP_MULT;
  end

  assign any_md = bus.op_div | bus.op_divu | bus.op_mult | bus.op_multu;
  assign any_op = any_md | bus.op_mthi | bus.op_mtlo | bus.op_mfhi | bus.op_mflo;
  assign start  = any_md & ~core_busy;

  muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .kind   (kind),
    .a      (bus.alu_a),
    .b      (bus.alu_b),
    .busy   (core_busy),
    .fin    (fin),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

  // fin only occurs while busy, so it never collides with a new start or an mthi/mtlo.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= fin;
      if (fin) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (start) begin
        dz_q <= is_div_op(kind) && (bus.alu_b == '0);
      end else if (!core_busy && bus.op_mthi) begin
        hi_q <= bus.alu_a;
      end else if (!core_busy && bus.op_mtlo) begin
        lo_q <= bus.alu_a;
      end
    end
  end

  assign bus.busy       = core_busy;
  assign bus.stall      = core_busy & any_op;
  assign bus.done       = done_q;
  assign bus.div_zero   = dz_q;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;
  assign bus.hilo_rdata = bus.op_mfhi ? hi_q : (bus.op_mflo ? lo_q : '0);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: expected HI/LO/div_zero go into a scoreboard queue
// at issue time and a negedge monitor pops one entry per done pulse.
module tb_muldiv_ctrl;
  localparam int W = 32;

  localparam logic [7:0] S_NONE  = 8'h00;
  localparam logic [7:0] S_MULT  = 8'h01;
  localparam logic [7:0] S_MULTU = 8'h02;
  localparam logic [7:0] S_DIV   = 8'h04;
  localparam logic [7:0] S_DIVU  = 8'h08;
  localparam logic [7:0] S_MTHI  = 8'h10;
  localparam logic [7:0] S_MTLO  = 8'h20;
  localparam logic [7:0] S_MFHI  = 8'h40;
  localparam logic [7:0] S_MFLO  = 8'h80;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    string        tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_ctrl_if #(.WIDTH(W)) bus();
  muldiv_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [7:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.op_mult  = s[0];
    bus.op_multu = s[1];
    bus.op_div   = s[2];
    bus.op_divu  = s[3];
    bus.op_mthi  = s[4];
    bus.op_mtlo  = s[5];
    bus.op_mfhi  = s[6];
    bus.op_mflo  = s[7];
    bus.alu_a    = a;
    bus.alu_b    = b;
  endtask

  task automatic expect_res(input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dz,
                            input string tag);
    exp_t e;
    e.hi  = hi;
    e.lo  = lo;
    e.dz  = dz;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Called on the negedge right after the accepting edge; busy must last 33 cycles.
  task automatic wait_done(input string name);
    int n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({name, "_busy_cycles"}, W'(n), 32'd33);
    chk({name, "_done"}, {31'd0, bus.done}, 32'd1);
  endtask

  task automatic run(input logic [7:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dz,
                     input string tag);
    expect_res(hi, lo, dz, tag);
    drive(s, a, b);
    @(negedge clk);
    drive(S_NONE, '0, '0);
    wait_done(tag);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending result");
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.tag, "_hi"}, bus.hi, mon_e.hi);
        chk({mon_e.tag, "_lo"}, bus.lo, mon_e.lo);
        chk({mon_e.tag, "_div_zero"}, {31'd0, bus.div_zero}, {31'd0, mon_e.dz});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    drive(S_NONE, '0, '0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_div_zero", {31'd0, bus.div_zero}, 32'd0);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: unsigned max * max, single-cycle done
    run(S_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "t1");
    @(negedge clk);
    chk("t1_done_one_cycle", {31'd0, bus.done}, 32'd0);

    // 2: signed mult, second mult held off by stall until done
    expect_res(32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, "t2a");
    drive(S_MULT, 32'hFFFF_FFFE, 32'd3);
    @(negedge clk);
    drive(S_NONE, '0, '0);
    repeat (5) @(negedge clk);
    expect_res(32'hFFFF_FFFF, 32'hFFFF_FFEC, 1'b0, "t2b");
    drive(S_MULT, 32'd5, 32'hFFFF_FFFC);
    #1;
    chk("t2_stall_busy", {31'd0, bus.stall}, 32'd1);
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("t2a_remaining_cycles", W'(n), 32'd28);
    chk("t2_stall_released", {31'd0, bus.stall}, 32'd0);
    @(negedge clk);
    drive(S_NONE, '0, '0);
    wait_done("t2b");

    // 3: signed div, divide by zero, div_zero cleared by next op
    run(S_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "t3_div");
    run(S_DIVU, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 1'b1, "t3_divu0");
    run(S_MULTU, 32'd1, 32'd1, 32'd0, 32'd1, 1'b0, "t3_multu");

    // 4: mthi/mtlo writes and mfhi/mflo reads
    drive(S_MTHI, 32'h0000_1234, '0);
    @(negedge clk);
    drive(S_NONE, '0, '0);
    chk("t4_mthi_hi", bus.hi, 32'h0000_1234);
    chk("t4_mthi_busy", {31'd0, bus.busy}, 32'd0);
    chk("t4_mthi_done", {31'd0, bus.done}, 32'd0);
    drive(S_MTLO, 32'h0000_5678, '0);
    @(negedge clk);
    drive(S_NONE, '0, '0);
    chk("t4_mtlo_lo", bus.lo, 32'h0000_5678);
    chk("t4_mtlo_hi_kept", bus.hi, 32'h0000_1234);
    drive(S_MFLO, '0, '0);
    #1;
    chk("t4_mflo_rdata", bus.hilo_rdata, 32'h0000_5678);
    drive(S_MFHI, '0, '0);
    #1;
    chk("t4_mfhi_rdata", bus.hilo_rdata, 32'h0000_1234);
    drive(S_NONE, '0, '0);
    #1;
    chk("t4_idle_rdata", bus.hilo_rdata, 32'd0);
    drive(S_MTHI | S_MTLO, 32'h0000_AAAA, '0);
    @(negedge clk);
    drive(S_NONE, '0, '0);
    chk("t4_prio_hi", bus.hi, 32'h0000_AAAA);
    chk("t4_prio_lo", bus.lo, 32'h0000_5678);

    // 5: signed overflow, div_zero cleared by a div
    run(S_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1'b1, "t5_divu0");
    run(S_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, "t5_ovf");

    // 6: reset mid-operation aborts without writing HI/LO
    drive(S_DIV, 32'd100, 32'd7);
    @(negedge clk);
    drive(S_NONE, '0, '0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("t6_rst_hi", bus.hi, 32'd0);
    chk("t6_rst_lo", bus.lo, 32'd0);
    chk("t6_rst_done", {31'd0, bus.done}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_no_done", {31'd0, bus.done}, 32'd0);
    end
    run(S_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "t6_mult");

    repeat (3) @(negedge clk);
    chk("sb_empty", W'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Iterative multiply/divide sequencer that owns the HI/LO register pair of the MiniSys1A core.
- Consumes the decoder's mult/multu/div/divu/mthi/mtlo/mfhi/mflo strobes and the two operand buses that also feed alu_32.
- Runs a 32-step shift-add multiply or restoring divide, applies a sign-fix step, and writes HI/LO.
- Raises stall while a HI/LO access would conflict with an operation in flight.

Parameters:
WIDTH, 32, operand width; HI and LO are WIDTH each; iteration count equals WIDTH.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
op_mult  input  1  decoder strobe, signed multiply
op_multu  input  1  decoder strobe, unsigned multiply
op_div  input  1  decoder strobe, signed divide
op_divu  input  1  decoder strobe, unsigned divide
op_mthi  input  1  write alu_a to HI
op_mtlo  input  1  write alu_a to LO
op_mfhi  input  1  read HI onto hilo_rdata
op_mflo  input  1  read LO onto hilo_rdata
alu_a  input  WIDTH  rs operand (multiplicand / dividend / mthi-mtlo data)
alu_b  input  WIDTH  rt operand (multiplier / divisor)
busy  output  1  high while state is not IDLE
stall  output  1  combinational: busy AND any of the eight op_* strobes asserted
done  output  1  one-cycle pulse when HI/LO have been written by mult/div
div_zero  output  1  registered, set by a div/divu with alu_b==0, cleared by the next accepted mult/div
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
hilo_rdata  output  WIDTH  combinational: hi if op_mfhi, lo if op_mflo, else 0

Behaviour:
- Reset: clock and reset are a single clock `clk` and a synchronous active-low reset `rst_n`, sampled on the rising edge of clk. While reset is asserted:
  - hi, lo = 0; busy, done, div_zero = 0; state = IDLE; iteration counter = 0.
  - Reset mid-operation aborts with no HI/LO write.
- States: IDLE, RUN, FIX.
- Acceptance: only in IDLE and only when rst_n=1.
  - Priority when several strobes are asserted: div > divu > mult > multu > mthi > mtlo.
  - Strobes arriving while busy are ignored. stall tells the pipeline to hold and re-present them.
- mthi/mtlo in IDLE: hi (or lo) = alu_a at that edge. No state change, no done.
- mult/div accepted at edge T0:
  - Latch |alu_a| and |alu_b| (magnitudes for signed ops, raw values for unsigned).
  - Latch the sign-fix flags and op kind; counter=0; state=RUN.
- RUN: one iteration per edge, counter 0..WIDTH-1.
  - Multiply: 2*WIDTH-bit shift-add on the magnitudes.
  - Divide: restoring shift-subtract on the magnitudes.
  - The edge at counter=WIDTH-1 moves to FIX.
- FIX (one edge): write the results into hi/lo, pulse done, return to IDLE.
  - Signed mult: negate the 2*WIDTH product if the operand signs differ. hi = upper half, lo = lower half.
  - Signed div: quotient negated if the signs differ; remainder takes the dividend's sign. lo = quotient, hi = remainder.
  - done is high for the single cycle following the FIX edge.
- Latency: accepted at T0 → done high in the cycle after edge T0+WIDTH+1 (T0+33 for WIDTH=32). The new hi/lo are visible in that same cycle.
- busy is high from the cycle after T0 through the cycle in which state=FIX.
- A new operation may be accepted in the cycle done is high (state is IDLE).
- Divide by zero (alu_b==0): still takes full latency. Result is lo=all-ones, hi=alu_a (original signed value), div_zero=1.
- Overflow: signed div of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0. No flag, no exception.
- hi/lo hold their value between writes. mfhi/mflo never modify state.
- hilo_rdata is valid only when stall=0; when stall=1 it is don't-care.

Decomposition:
- Shared package: state encoding (IDLE/RUN/FIX) and WIDTH default constant; the op-kind encoding (MULT, MULTU, DIV, DIVU) used by the decoder and this block.
- One sub-module is natural: muldiv_core, holding the iterative datapath (accumulator, shift register, counter, magnitude/sign-fix logic) with start/done handshake.
- muldiv_ctrl keeps priority decode, HI/LO registers, stall and read mux.

Test Plan:
1. multu alu_a=0xFFFFFFFF, alu_b=0xFFFFFFFF at T0 → done in the cycle after edge T0+33; hi=0xFFFFFFFE, lo=0x00000001; busy high for exactly 33 cycles.
2. mult alu_a=-2 (0xFFFFFFFE), alu_b=3 → hi=0xFFFFFFFF, lo=0xFFFFFFFA; a second mult presented during busy gives stall=1 and is not accepted until done.
3. div alu_a=-7, alu_b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); then divu 7/0 → lo=0xFFFFFFFF, hi=7, div_zero=1; then multu 1*1 → div_zero=0.
4. mthi alu_a=0x1234 in IDLE → hi=0x1234 after one edge, no done; then mflo with lo=0x5678 → hilo_rdata=0x5678 same cycle.
5. div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0, div_zero=0.
6. Start div, drive rst_n=0 at edge T0+10 → busy=0, hi=lo=0, no done pulse; a mult accepted the cycle after rst_n returns high completes normally.
